// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, branch/jump targets and interrupt/exception vectoring
// Optional interrupt counter output irq_count is enabled by defining PC_IRQ_STATS_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        irq,
    input  logic        bad_op,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        kernel,
    output logic        k0_we,
    output logic [31:0] k0_data,
    output logic        squash
`ifdef PC_IRQ_STATS_EN
    ,
    output logic [15:0] irq_count
`endif
);

    typedef enum logic [1:0] {
        USER  = 2'd0,
        KERN  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        irq_q;
    logic [31:0] pc_next;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        take_exc;
    logic        take_irq;

    assign pc_plus4      = pc + 32'd4;
    assign kernel        = pc[31];
    assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};

    // User code may never compute a kernel-space target; bit 31 is cleared.
    always_comb begin
        branch_target = pc_plus4 + branch_offset;
        jump_target   = {pc_plus4[31:28], index26, 2'b00};
        if (!pc[31]) begin
            branch_target[31] = 1'b0;
            jump_target[31]   = 1'b0;
        end
    end

    assign take_exc = !reset && !stall && bad_op;
    assign take_irq = !reset && !stall && !bad_op && irq_q && (state == USER);
    assign k0_we    = take_exc || take_irq;
    assign squash   = take_exc || take_irq;
    assign k0_data  = take_exc ? pc_plus4 : pc;

    always_comb begin
        pc_next    = pc;
        state_next = state;
        if (!stall) begin
            if (take_exc) begin
                pc_next    = EXC_VEC;
                state_next = KERN;
            end else if (take_irq) begin
                pc_next    = IRQ_VEC;
                state_next = KERN;
            end else if (jr) begin
                pc_next = jr_target;
                if (jr_target[31])
                    state_next = KERN;
                else if (state == KERN)
                    state_next = GUARD;
                else
                    state_next = USER;
            end else begin
                if (jump)
                    pc_next = jump_target;
                else if (branch_taken)
                    pc_next = branch_target;
                else
                    pc_next = pc_plus4;
                if (state == GUARD)
                    state_next = USER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_VEC;
            irq_q <= 1'b0;
            state <= KERN;
        end else begin
            pc    <= pc_next;
            irq_q <= irq;
            state <= state_next;
        end
    end

`ifdef PC_IRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            irq_count <= 16'd0;
        else if (take_irq && (irq_count != 16'hFFFF))
            irq_count <= irq_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        irq = 1'b0;
    logic        bad_op = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] index26 = 26'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        kernel;
    logic        k0_we;
    logic [31:0] k0_data;
    logic        squash;
`ifdef PC_IRQ_STATS_EN
    logic [15:0] irq_count;
`endif

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .irq(irq), .bad_op(bad_op),
        .branch_taken(branch_taken), .jump(jump), .jr(jr), .jr_target(jr_target),
        .imm16(imm16), .index26(index26), .pc(pc), .pc_plus4(pc_plus4),
        .kernel(kernel), .k0_we(k0_we), .k0_data(k0_data), .squash(squash)
`ifdef PC_IRQ_STATS_EN
        , .irq_count(irq_count)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: mode 0 = user, 1 = kernel, 2 = first user instruction after return.
    logic [31:0] m_pc;
    logic        m_irqq;
    int          m_mode;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; irq = 0; bad_op = 0; branch_taken = 0; jump = 0; jr = 0;
        jr_target = 0; imm16 = 0; index26 = 0;
    endtask

    task automatic do_reset();
        reset = 1; bad_op = 1; irq = 1;
        @(negedge clk);
        chk("k0_we_in_reset", {31'b0, k0_we}, 32'd0);
        chk("squash_in_reset", {31'b0, squash}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        clear_inputs();
        m_pc = RESET_VEC; m_irqq = 0; m_mode = 1; m_cnt = 0;
    endtask

    task automatic step();
        logic        exc, vec;
        logic [31:0] p4, np;
        int          nm, off;
        @(negedge clk);
        p4  = m_pc + 32'd4;
        exc = !stall && bad_op;
        vec = !stall && !bad_op && m_irqq && (m_mode == 0);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, p4);
        chk("kernel", {31'b0, kernel}, {31'b0, m_pc[31]});
        chk("k0_we", {31'b0, k0_we}, {31'b0, exc || vec});
        chk("squash", {31'b0, squash}, {31'b0, exc || vec});
        if (exc || vec)
            chk("k0_data", k0_data, exc ? p4 : m_pc);
`ifdef PC_IRQ_STATS_EN
        chk("irq_count", {16'b0, irq_count}, {16'b0, m_cnt});
`endif
        np = m_pc;
        nm = m_mode;
        if (stall) begin
            np = m_pc;
        end else if (exc) begin
            np = EXC_VEC; nm = 1;
        end else if (vec) begin
            np = IRQ_VEC; nm = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (jr) begin
            np = jr_target;
            if (jr_target[31]) nm = 1;
            else if (m_mode == 1) nm = 2;
            else nm = 0;
        end else begin
            if (jump) begin
                np = (p4 & 32'hF000_0000) | ({6'b0, index26} * 32'd4);
            end else if (branch_taken) begin
                off = int'($signed(imm16));
                np = p4 + 32'(off * 4);
            end else begin
                np = p4;
            end
            if (!m_pc[31]) np[31] = 1'b0;
            if (m_mode == 2) nm = 0;
        end
        @(posedge clk); #1;
        m_pc = np;
        m_mode = nm;
        m_irqq = irq;
    endtask

    initial begin
        m_pc = RESET_VEC; m_irqq = 0; m_mode = 1; m_cnt = 0;
        @(posedge clk); #1;
        do_reset();
        chk("reset_pc", pc, 32'h8000_0000);
        step(); step(); step();
        chk("idle_pc_3", pc, 32'h8000_000C);

        jr = 1; jr_target = 32'h0000_000C; step();
        jr = 0; step();
        chk("user_pc_10", pc, 32'h0000_0010);
        branch_taken = 1; imm16 = 16'hFFFD; step();
        branch_taken = 0;
        chk("branch_back", pc, 32'h0000_0008);
        jump = 1; index26 = 26'h3FF_FFFF; step();
        jump = 0;
        chk("user_jump_pc", pc, 32'h0FFF_FFFC);
        chk("user_jump_kernel", {31'b0, kernel}, 32'd0);

        jr = 1; jr_target = 32'h0000_003C; step();
        jr = 0; step();
        chk("pc_40", pc, 32'h0000_0040);
        irq = 1; step();
        irq = 0; step();
        chk("irq_vector", pc, IRQ_VEC);

        irq = 1; jr = 1; jr_target = 32'h0000_0040; step();
        jr = 0; step();
        chk("guard_commit", pc, 32'h0000_0044);
        step();
        chk("irq_after_guard", pc, IRQ_VEC);
        irq = 0;

        irq = 1; jr = 1; jr_target = 32'h0000_001C; step();
        jr = 0; step();
        chk("pc_20", pc, 32'h0000_0020);
        bad_op = 1; step();
        bad_op = 0; irq = 0;
        chk("exc_vector", pc, EXC_VEC);

        jr = 1; jr_target = 32'h0000_0100; step();
        jr = 0; step();
        stall = 1; step();
        irq = 1; step(); step(); step();
        chk("stall_hold", pc, 32'h0000_0104);
        stall = 0; irq = 0; step();
        chk("vector_after_stall", pc, IRQ_VEC);

        do_reset();
        chk("reset_mid_handler", pc, RESET_VEC);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                stall        = ($urandom_range(0, 7) == 0);
                irq          = ($urandom_range(0, 3) == 0);
                bad_op       = ($urandom_range(0, 19) == 0);
                jr           = ($urandom_range(0, 7) == 0);
                jump         = ($urandom_range(0, 7) == 0);
                branch_taken = ($urandom_range(0, 5) == 0);
                jr_target    = $urandom & 32'h8000_03FC;
                imm16        = 16'($urandom);
                index26      = 26'($urandom) & 26'h000_03FF;
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
